// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences a multi-cycle divider and handles MTHI/MTLO writes.
// Stalls the pipeline via busy while a division is in flight.
module hilo_ctrl #(
  parameter int unsigned TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic [1:0]  op_sel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        div_go,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_end,
  input  logic        div_zero,
  input  logic [31:0] div_high,
  input  logic [31:0] div_low,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        dz_exc,
  output logic        tmo_err
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

  localparam logic [5:0] CntLast = 6'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;
  logic        tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    tmo_d   = tmo_q;
    div_go  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Operands only move here, so they hold steady for the whole division.
        if (op_start) begin
          unique case (op_sel)
            2'b00: begin
              a_d     = rs_val;
              b_d     = rt_val;
              state_d = StLaunch;
            end
            2'b01:   hi_d = rs_val;
            2'b10:   lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StLaunch: begin
        div_go  = 1'b1;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 6'd1;
        if (div_zero) begin
          dz_d    = 1'b1;
          state_d = StDone;
        end else if (div_end) begin
          hi_d    = div_high;
          lo_d    = div_low;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        dz_d    = 1'b0;
        tmo_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign div_a   = a_q;
  assign div_b   = b_q;
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign dz_exc  = dz_q;
  assign tmo_err = tmo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed scenarios plus randomized ops against
// an arithmetic model of HI/LO and completion timing, with a behavioural divider.
module tb_hilo_ctrl;

  localparam int Tmo = 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_start = 1'b0;
  logic [1:0]  op_sel = 2'b11;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        div_go;
  logic [31:0] div_a, div_b;
  logic        div_end = 1'b0;
  logic        div_zero = 1'b0;
  logic [31:0] div_high = '0;
  logic [31:0] div_low = '0;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, dz_exc, tmo_err;

  int          vectors = 0;
  int          miscompares = 0;
  bit          hang = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  hilo_ctrl #(.TIMEOUT(Tmo)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_start (op_start),
    .op_sel   (op_sel),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .div_go   (div_go),
    .div_a    (div_a),
    .div_b    (div_b),
    .div_end  (div_end),
    .div_zero (div_zero),
    .div_high (div_high),
    .div_low  (div_low),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .dz_exc   (dz_exc),
    .tmo_err  (tmo_err)
  );

  always #5 clk = ~clk;

  // Behavioural divider: 32 cycles after load, zero-divisor pulse right after load,
  // or silence when hang is set. It ignores reset, so it can finish after an abort.
  int          dcnt = 0;
  logic [31:0] pend_q, pend_r;
  always @(posedge clk) begin
    div_zero <= 1'b0;
    if (div_go) begin
      div_end <= 1'b0;
      if (hang) begin
        dcnt <= 0;
      end else if (div_b == 32'd0) begin
        div_zero <= 1'b1;
        dcnt     <= 0;
      end else begin
        dcnt   <= 32;
        pend_q <= $signed(div_a) / $signed(div_b);
        pend_r <= $signed(div_a) % $signed(div_b);
      end
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        div_end  <= 1'b1;
        div_high <= pend_r;
        div_low  <= pend_q;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " hi"}, hi_out, exp_hi);
    check({tag, " lo"}, lo_out, exp_lo);
  endtask

  // MTHI (sel 01), MTLO (sel 10), no-op (sel 11) or start=0: single IDLE cycle.
  task automatic do_simple(input logic start, input logic [1:0] sel, input logic [31:0] v,
                           input string tag);
    op_start = start;
    op_sel   = sel;
    rs_val   = v;
    tick();
    op_start = 1'b0;
    if (start && sel == 2'b01) exp_hi = v;
    if (start && sel == 2'b10) exp_lo = v;
    check_idle(tag);
  endtask

  // Full DIV transaction; k counts edges after the sampling edge until done is seen.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit noisy,
                        input string tag);
    int          k;
    int          exp_k;
    logic        exp_dz, exp_tmo, extra_go;
    logic [31:0] ehi, elo;
    ehi = exp_hi;
    elo = exp_lo;
    exp_dz = 1'b0;
    exp_tmo = 1'b0;
    if (hang) begin
      exp_k = Tmo + 1;
      exp_tmo = 1'b1;
    end else if (b == 32'd0) begin
      exp_k = 2;
      exp_dz = 1'b1;
    end else begin
      exp_k = 34;
      ehi = $signed(a) % $signed(b);
      elo = $signed(a) / $signed(b);
    end
    op_start = 1'b1;
    op_sel   = 2'b00;
    rs_val   = a;
    rt_val   = b;
    tick();
    op_start = 1'b0;
    check({tag, " go"}, div_go, 1);
    check({tag, " busy"}, busy, 1);
    k = 0;
    extra_go = 1'b0;
    while (!done && k < 100) begin
      if (noisy) begin
        op_start = 1'($urandom);
        op_sel   = 2'($urandom);
        rs_val   = $urandom;
      end
      tick();
      op_start = 1'b0;
      k++;
      if (div_go) extra_go = 1'b1;
    end
    check({tag, " latency"}, k, exp_k);
    check({tag, " go once"}, extra_go, 0);
    check({tag, " dz"}, dz_exc, exp_dz);
    check({tag, " tmo"}, tmo_err, exp_tmo);
    check({tag, " hi"}, hi_out, ehi);
    check({tag, " lo"}, lo_out, elo);
    check({tag, " div_a"}, div_a, a);
    check({tag, " div_b"}, div_b, b);
    exp_hi = ehi;
    exp_lo = elo;
    tick();
    check_idle({tag, " after"});
    check({tag, " flags clr"}, {30'd0, dz_exc, tmo_err}, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    int          r;
    bit          saw_done;

    tick();
    tick();
    reset = 1'b0;
    check("rst hi", hi_out, 0);
    check("rst lo", lo_out, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst go", div_go, 0);
    check("rst div_a", div_a, 0);

    do_div(32'd100, 32'd7, 1'b0, "div 100/7");
    do_div(32'hFFFF_FF9C, 32'd7, 1'b0, "div -100/7");
    do_div(32'd5, 32'd0, 1'b0, "div 5/0");
    do_simple(1'b1, 2'b01, 32'hDEAD_BEEF, "mthi");
    do_simple(1'b1, 2'b10, 32'h1234_5678, "mtlo");
    do_simple(1'b1, 2'b11, 32'hFFFF_FFFF, "nop sel11");
    do_simple(1'b0, 2'b01, 32'h0BAD_0BAD, "nop start0");

    hang = 1'b1;
    do_div(32'd77, 32'd5, 1'b0, "div timeout");
    hang = 1'b0;

    // Abort in the 10th WAIT cycle; the divider still finishes later and must be ignored.
    op_start = 1'b1;
    op_sel   = 2'b00;
    rs_val   = 32'd1000;
    rt_val   = 32'd3;
    tick();
    op_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort busy pre", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check_idle("abort");
    check("abort div_a", div_a, 0);
    check("abort dz", dz_exc, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort quiet", saw_done, 0);
    check_idle("abort late");
    do_div(32'd9, 32'd3, 1'b0, "div 9/3");

    for (int n = 0; n < 16; n++) begin
      r = $urandom_range(0, 5);
      if (r <= 1) begin
        a = $urandom;
        b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        if (b == 32'hFFFF_FFFF && a == 32'h8000_0000) a = 32'd1;
        do_div(a, b, 1'b1, "rand div");
      end else if (r == 2) begin
        do_simple(1'b1, 2'b01, $urandom, "rand mthi");
      end else if (r == 3) begin
        do_simple(1'b1, 2'b10, $urandom, "rand mtlo");
      end else if (r == 4) begin
        do_simple(1'b1, 2'b11, $urandom, "rand nop");
      end else begin
        do_simple(1'b0, 2'($urandom), $urandom, "rand idle");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have the following parameter: TIMEOUT, default 48, maximum number of WAIT cycles before the operation is abandoned.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- op_start  in  1  request strobe, sampled only in IDLE
- op_sel  in  2  00 DIV, 01 MTHI, 10 MTLO, 11 no-op
- rs_val  in  32  dividend / MTHI / MTLO source
- rt_val  in  32  divisor
- div_go  out  1  one-cycle start pulse to divider
- div_a  out  32  latched dividend
- div_b  out  32  latched divisor
- div_end  in  1  divider completion level (cleared by divider on div_go)
- div_zero  in  1  divider zero-divisor pulse
- div_high  in  32  divider remainder
- div_low  in  32  divider quotient
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- busy  out  1  high in any state except IDLE (pipeline stall)
- done  out  1  one-cycle completion pulse
- dz_exc  out  1  divide-by-zero flag, valid only with done
- tmo_err  out  1  timeout flag, valid only with done

Function
REQ-004 The FSM SHALL have exactly the states IDLE, LAUNCH, WAIT and DONE, registered on clk.
REQ-005 In IDLE with op_start=1 and op_sel=00: latch rs_val into div_a and rt_val into div_b; next state LAUNCH.
REQ-006 In IDLE with op_start=1 and op_sel=01: HI <= rs_val at that edge; remain IDLE; no done pulse.
REQ-007 In IDLE with op_start=1 and op_sel=10: LO <= rs_val at that edge; remain IDLE; no done pulse.
REQ-008 In IDLE, op_sel=11 or op_start=0 SHALL have no effect.
REQ-009 In LAUNCH: div_go=1 for exactly that cycle; clear the wait counter; next state WAIT.
REQ-010 div_go SHALL be 0 in every state other than LAUNCH.
REQ-011 div_a and div_b SHALL remain stable from LAUNCH until return to IDLE.
REQ-012 In WAIT the 6-bit wait counter SHALL increment each cycle; transitions are evaluated in priority order (first match wins):
- div_zero=1: set dz_exc, HI/LO unchanged, next state DONE;
- else div_end=1: HI <= div_high, LO <= div_low, next state DONE;
- else counter = TIMEOUT-1: set tmo_err, HI/LO unchanged, next state DONE.
REQ-013 In DONE: done=1 for one cycle; next state IDLE; dz_exc and tmo_err cleared on leaving DONE.
REQ-014 With a conformant divider, the latency from the edge E0 sampling op_start SHALL be: LAUNCH after E0, divider load at E1, div_end seen after E33, capture at E34, done high in the cycle after E34 (35 cycles total).
REQ-015 With a zero divisor, done and dz_exc SHALL be high in the cycle after E2.
REQ-016 busy SHALL be combinational from state: 1 in LAUNCH, WAIT and DONE; 0 in IDLE.
REQ-017 op_start while busy=1 SHALL be ignored, with no queuing.
REQ-018 hi_out and lo_out SHALL continuously reflect HI and LO.
REQ-019 A stale div_end=1 held over from a previous operation SHALL never be sampled, because the divider clears it at the LAUNCH edge.

Reset
REQ-020 reset=1 at a clock edge SHALL force state IDLE, HI=LO=0, div_a=div_b=0, wait counter 0, and div_go=busy=done=dz_exc=tmo_err=0.
REQ-021 reset SHALL have priority over op_start and all FSM transitions in the same cycle.
REQ-022 reset asserted in LAUNCH or WAIT SHALL abort the operation, after which later div_end/div_zero SHALL be ignored until the next launch.

Verification
REQ-023 The bench SHALL cover these scenarios (stimulus -> required response):
- DIV rs=100, rt=7 -> done after 35 cycles; lo_out=14, hi_out=2; dz_exc=0.
- DIV rs=-100 (0xFFFFFF9C), rt=7 -> lo_out=0xFFFFFFF2 (-14), hi_out=0xFFFFFFFE (-2).
- DIV rs=5, rt=0 -> done and dz_exc=1 in the cycle after E2; HI/LO keep prior values.
- MTHI 0xDEADBEEF, then next-cycle MTLO 0x12345678 -> hi_out/lo_out updated; busy stays 0.
- DIV with a divider model that never raises div_end -> done and tmo_err=1 after 48 WAIT cycles; HI/LO unchanged.
- reset pulsed in the 10th WAIT cycle -> IDLE next cycle, HI=LO=0, no done; a following DIV 9/3 -> lo=3, hi=0.
